dot_product_sequencer: RTL and testbench

//  Sequences the dot-product datapath over the constellation table for modulation M.

---
 rtl/dot_product_sequencer_if.sv | 53 +++++
 rtl/dot_product_sequencer.sv | 136 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_sequencer_if.sv
// Handshake and bus bundle between the control FSM, the dot-product
// sequencer, the constellation RAM read port and the external MAC unit.
interface dot_product_sequencer_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  abort;
    logic [1:0]            M;
    logic                  rdEn;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic                  macClr;
    logic                  macEn;
    logic                  macSel;
    logic                  outValid;
    logic                  outReady;
    logic [7:0]            outIdx;
    logic                  busy;
    logic                  done;

    // The sequencer side drives the RAM/MAC controls and the result handshake.
    modport master (
        input  start,
        input  abort,
        input  M,
        input  outReady,
        output rdEn,
        output rdAddr,
        output macClr,
        output macEn,
        output macSel,
        output outValid,
        output outIdx,
        output busy,
        output done
    );

    // The surrounding control logic requests runs and consumes results.
    modport slave (
        output start,
        output abort,
        output M,
        output outReady,
        input  rdEn,
        input  rdAddr,
        input  macClr,
        input  macEn,
        input  macSel,
        input  outValid,
        input  outIdx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: walks the constellation table for the latched
// modulation, reading real (2k) then imag (2k+1) words, steering the MAC,
// handing one result per point downstream and pulsing done at the end.
module dot_product_sequencer #(
    parameter int ADDR_WIDTH = 9
) (
    input logic                    clk,
    input logic                    rst,
    dot_product_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_RE,
        RD_IM,
        ACC,
        EMIT,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] k;
    logic [1:0] mode;
    logic [7:0] last_k;
    logic [7:0] k_inc;

    // Table word address of point idx: real at even, imag at odd, zero-extended.
    function automatic logic [ADDR_WIDTH-1:0] point_addr(input logic [7:0] idx,
                                                         input logic       imag);
        return ADDR_WIDTH'({idx, imag});
    endfunction

    // Index of the final constellation point for the latched modulation.
    always_comb begin
        case (mode)
            2'b00:   last_k = 8'd3;
            2'b01:   last_k = 8'd15;
            2'b10:   last_k = 8'd63;
            default: last_k = 8'd255;
        endcase
    end

    assign k_inc = k + 8'd1;

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            k            <= 8'd0;
            mode         <= 2'b00;
            bus.rdEn     <= 1'b0;
            bus.rdAddr   <= '0;
            bus.macClr   <= 1'b0;
            bus.macEn    <= 1'b0;
            bus.macSel   <= 1'b0;
            bus.outValid <= 1'b0;
            bus.outIdx   <= 8'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.rdEn     <= 1'b0;
            bus.rdAddr   <= '0;
            bus.macClr   <= 1'b0;
            bus.macEn    <= 1'b0;
            bus.macSel   <= 1'b0;
            bus.outValid <= 1'b0;
            bus.outIdx   <= 8'd0;
            bus.done     <= 1'b0;

            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                k        <= 8'd0;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.busy <= 1'b0;
                        if (bus.start) begin
                            mode       <= bus.M;
                            k          <= 8'd0;
                            state      <= RD_RE;
                            bus.busy   <= 1'b1;
                            bus.rdEn   <= 1'b1;
                            bus.rdAddr <= point_addr(8'd0, 1'b0);
                            bus.macClr <= 1'b1;
                        end
                    end
                    RD_RE: begin
                        state      <= RD_IM;
                        bus.rdEn   <= 1'b1;
                        bus.rdAddr <= point_addr(k, 1'b1);
                        bus.macEn  <= 1'b1;
                        bus.macSel <= 1'b0;
                    end
                    RD_IM: begin
                        state      <= ACC;
                        bus.macEn  <= 1'b1;
                        bus.macSel <= 1'b1;
                    end
                    ACC: begin
                        state        <= EMIT;
                        bus.outValid <= 1'b1;
                        bus.outIdx   <= k;
                    end
                    EMIT: begin
                        if (bus.outReady) begin
                            if (k == last_k) begin
                                state    <= DONE;
                                bus.done <= 1'b1;
                            end else begin
                                k          <= k_inc;
                                state      <= RD_RE;
                                bus.rdEn   <= 1'b1;
                                bus.rdAddr <= point_addr(k_inc, 1'b0);
                                bus.macClr <= 1'b1;
                            end
                        end else begin
                            bus.outValid <= 1'b1;
                            bus.outIdx   <= k;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        k        <= 8'd0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: a per-cycle expected trace is
// expanded from the point/stall/abort rules and compared against the DUT.
module tb_dot_product_sequencer;

    logic clk = 1'b0;
    logic rst;

    dot_product_sequencer_if #(.ADDR_WIDTH(9)) bus();

    dot_product_sequencer #(.ADDR_WIDTH(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd_en;
        logic [8:0] rd_addr;
        logic       mac_clr;
        logic       mac_en;
        logic       mac_sel;
        logic       out_valid;
        logic [7:0] out_idx;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   addr_care;
        bit   idx_care;
        bit   is_emit;
        bit   ready;
    } step_t;

    step_t plan[$];
    int    stall_plan[256];
    int    checks = 0;
    int    errors = 0;

    function automatic step_t idle_step();
        step_t s;
        s.v         = '0;
        s.addr_care = 1'b1;
        s.idx_care  = 1'b1;
        s.is_emit   = 1'b0;
        s.ready     = 1'b0;
        return s;
    endfunction

    function automatic step_t busy_step();
        step_t s;
        s           = idle_step();
        s.v.busy    = 1'b1;
        s.addr_care = 1'b0;
        s.idx_care  = 1'b0;
        return s;
    endfunction

    function automatic void clear_stalls();
        for (int i = 0; i < 256; i++) stall_plan[i] = 0;
    endfunction

    // Expand a run of n points into the expected cycle-by-cycle trace.
    function automatic void build_plan(input int n, input int abort_at);
        step_t s;
        plan.delete();
        plan.push_back(idle_step());
        for (int p = 0; p < n; p++) begin
            s = busy_step();
            s.v.rd_en = 1'b1; s.v.rd_addr = 9'(2 * p); s.v.mac_clr = 1'b1; s.addr_care = 1'b1;
            plan.push_back(s);
            s = busy_step();
            s.v.rd_en = 1'b1; s.v.rd_addr = 9'(2 * p + 1); s.v.mac_en = 1'b1; s.addr_care = 1'b1;
            plan.push_back(s);
            s = busy_step();
            s.v.mac_en = 1'b1; s.v.mac_sel = 1'b1;
            plan.push_back(s);
            for (int w = 0; w <= stall_plan[p]; w++) begin
                s = busy_step();
                s.v.out_valid = 1'b1; s.v.out_idx = 8'(p); s.idx_care = 1'b1;
                s.is_emit = 1'b1; s.ready = (w == stall_plan[p]);
                plan.push_back(s);
            end
        end
        s = busy_step();
        s.v.done = 1'b1;
        plan.push_back(s);
        if (abort_at > 0) begin
            while (plan.size() > abort_at + 1) void'(plan.pop_back());
        end
        plan.push_back(idle_step());
        plan.push_back(idle_step());
    endfunction

    task automatic applyStimulus(input logic st, input logic [1:0] m, input logic rdy, input logic ab);
        bus.start    = st;
        bus.M        = m;
        bus.outReady = rdy;
        bus.abort    = ab;
    endtask

    task automatic checkOutput(input step_t s, input string tag);
        obs_t got;
        obs_t exp;
        got = {bus.rdEn, bus.rdAddr, bus.macClr, bus.macEn, bus.macSel,
               bus.outValid, bus.outIdx, bus.busy, bus.done};
        exp = s.v;
        if (!s.addr_care) begin got.rd_addr = '0; exp.rd_addr = '0; end
        if (!s.idx_care)  begin got.out_idx = '0; exp.out_idx = '0; end
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive the current plan; stop_at >= 0 leaves the run after that cycle.
    task automatic run_plan(input string name, input logic [1:0] mode, input int n,
                            input int abort_at, input bit noise, input int stop_at);
        int active_end;
        int seen_done;
        int exp_done;
        active_end = plan.size() - 3;
        seen_done  = -1;
        exp_done   = 4 * n + 1;
        for (int p = 0; p < n; p++) exp_done += stall_plan[p];
        if (abort_at > 0) exp_done = -1;
        for (int c = 0; c < plan.size(); c++) begin
            @(negedge clk);
            checkOutput(plan[c], $sformatf("%s c%0d", name, c));
            if (bus.done === 1'b1 && seen_done < 0) seen_done = c;
            applyStimulus((c == 0) ? 1'b1 : ((noise && c <= active_end) ? 1'($urandom_range(0, 1)) : 1'b0),
                          (c == 0 || !noise) ? mode : 2'($urandom_range(0, 3)),
                          plan[c].is_emit ? plan[c].ready : 1'($urandom_range(0, 1)),
                          (c == abort_at));
            if (c == stop_at) return;
        end
        checkInt({name, " done_cycle"}, seen_done, exp_done);
    endtask

    initial begin
        int n;
        int abort_at;
        logic [1:0] mode;

        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput(idle_step(), "reset");
        rst = 1'b1;

        $display("[TB] QPSK straight run");
        clear_stalls();
        build_plan(4, -1);
        run_plan("qpsk", 2'b00, 4, -1, 1'b0, -1);

        $display("[TB] QAM256 straight run");
        build_plan(256, -1);
        run_plan("qam256", 2'b11, 256, -1, 1'b0, -1);

        $display("[TB] QAM16 with 5-cycle stall at point 2");
        clear_stalls();
        stall_plan[2] = 5;
        build_plan(16, -1);
        run_plan("qam16_stall", 2'b01, 16, -1, 1'b0, -1);

        $display("[TB] QAM64 abort during EMIT of point 5");
        clear_stalls();
        build_plan(64, 24);
        run_plan("qam64_abort", 2'b10, 64, 24, 1'b0, -1);

        $display("[TB] QAM16 with M changes and start pulses mid-run");
        build_plan(16, -1);
        run_plan("qam16_noise", 2'b01, 16, -1, 1'b1, -1);

        $display("[TB] reset during RD_IM of point 3");
        build_plan(16, -1);
        run_plan("rst_mid", 2'b01, 16, -1, 1'b0, 14);
        #2 rst = 1'b0;
        #1 checkOutput(idle_step(), "async_reset");
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        build_plan(4, -1);
        run_plan("after_rst", 2'b00, 4, -1, 1'b0, -1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            mode = 2'($urandom_range(0, 2));
            n    = 4 << (2 * mode);
            for (int p = 0; p < 256; p++)
                stall_plan[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * n)) : -1;
            build_plan(n, abort_at);
            run_plan($sformatf("rand%0d", r), mode, n, abort_at, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
